// File: rtl/control_sequencer.sv
// Hard-wired micro-sequencer for the datapath: shared fetch (T0-T2), then
// decode of the latched IR and execute steps for ALU3, MUL/DIV, NOP and HALT.
module control_sequencer #(
    parameter int NREG = 16
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            run,
    input  logic [31:0]     ir,
    output logic            PCout,
    output logic            incPC,
    output logic            MARin,
    output logic            Zin,
    output logic            PCin,
    output logic            Read,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Yin,
    output logic            ZLowOut,
    output logic            ZHighOut,
    output logic            HIin,
    output logic            LOin,
    output logic [NREG-1:0] reg_in,
    output logic [NREG-1:0] reg_out,
    output logic [4:0]      opcode,
    output logic            done,
    output logic            halted,
    output logic            illegal
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    state_t state, next_state;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       is_alu3, is_muldiv, is_nop, is_halt, is_illegal;
    logic       unused_ir_bits;

    assign op             = ir[31:27];
    assign ra             = ir[26:23];
    assign rb             = ir[22:19];
    assign rc             = ir[18:15];
    assign unused_ir_bits = ^ir[14:0];

    assign is_muldiv  = (op == 5'b00011) || (op == 5'b00100);
    assign is_alu3    = (op <= 5'b01011) && !is_muldiv;
    assign is_nop     = (op == 5'b11010);
    assign is_halt    = (op == 5'b11011);
    assign is_illegal = !(is_alu3 || is_muldiv || is_nop || is_halt);

    // Register indices beyond NREG decode to no select rather than wrapping.
    function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            if (i == int'(idx)) v[i] = 1'b1;
        end
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (run) next_state = T0;
            T0:   next_state = T1;
            T1:   next_state = T2;
            T2:   next_state = T3;
            T3: begin
                if (is_alu3 || is_muldiv) next_state = T4;
                else if (is_halt)         next_state = HALT;
                else                      next_state = run ? T0 : IDLE;
            end
            T4:   next_state = T5;
            T5: begin
                if (is_muldiv) next_state = T6;
                else           next_state = run ? T0 : IDLE;
            end
            T6:   next_state = run ? T0 : IDLE;
            HALT: next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are a pure decode of the current step and the latched IR.
    always_comb begin
        PCout    = 1'b0;
        incPC    = 1'b0;
        MARin    = 1'b0;
        Zin      = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        ZLowOut  = 1'b0;
        ZHighOut = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        reg_in   = '0;
        reg_out  = '0;
        opcode   = 5'b00000;
        done     = 1'b0;
        halted   = 1'b0;
        illegal  = 1'b0;
        case (state)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                incPC = 1'b1;
                Zin   = 1'b1;
            end
            T1: begin
                ZLowOut = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                if (is_alu3) begin
                    reg_out = onehot(rb);
                    Yin     = 1'b1;
                end else if (is_muldiv) begin
                    reg_out = onehot(ra);
                    Yin     = 1'b1;
                end else if (!is_halt) begin
                    done    = 1'b1;
                    illegal = is_illegal;
                end
            end
            T4: begin
                if (is_alu3) begin
                    reg_out = onehot(rc);
                    opcode  = op;
                    Zin     = 1'b1;
                end else if (is_muldiv) begin
                    reg_out = onehot(rb);
                    opcode  = op;
                    Zin     = 1'b1;
                end
            end
            T5: begin
                if (is_alu3) begin
                    ZLowOut = 1'b1;
                    reg_in  = onehot(ra);
                    done    = 1'b1;
                end else if (is_muldiv) begin
                    ZLowOut = 1'b1;
                    LOin    = 1'b1;
                end
            end
            T6: begin
                ZHighOut = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
            end
            HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed instruction streams plus
// randomized instructions against a per-instruction micro-step table model.
module tb_control_sequencer;

    localparam int NREG = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            clr, run;
    logic [31:0]     ir;
    logic            PCout, incPC, MARin, Zin, PCin, Read, MDRin, MDRout, IRin;
    logic            Yin, ZLowOut, ZHighOut, HIin, LOin;
    logic [NREG-1:0] reg_in, reg_out;
    logic [4:0]      opcode;
    logic            done, halted, illegal;

    control_sequencer #(.NREG(NREG)) dut (
        .clk(clk), .clr(clr), .run(run), .ir(ir),
        .PCout(PCout), .incPC(incPC), .MARin(MARin), .Zin(Zin), .PCin(PCin),
        .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .HIin(HIin), .LOin(LOin),
        .reg_in(reg_in), .reg_out(reg_out), .opcode(opcode),
        .done(done), .halted(halted), .illegal(illegal)
    );

    // Strobe vector order: PCout incPC MARin Zin PCin Read MDRin MDRout IRin Yin ZLowOut ZHighOut HIin LOin
    localparam int S_PCOUT = 13, S_INCPC = 12, S_MARIN = 11, S_ZIN = 10, S_PCIN = 9;
    localparam int S_READ = 8, S_MDRIN = 7, S_MDROUT = 6, S_IRIN = 5, S_YIN = 4;
    localparam int S_ZLO = 3, S_ZHI = 2, S_HIIN = 1, S_LOIN = 0;

    typedef struct packed {
        logic [13:0]     strobes;
        logic [NREG-1:0] reg_in;
        logic [NREG-1:0] reg_out;
        logic [4:0]      opcode;
        logic            done;
        logic            halted;
        logic            illegal;
    } obs_t;

    typedef enum {C_ALU, C_MD, C_NOP, C_HALT, C_ILL} cls_t;

    int errors = 0;
    int checks = 0;

    function automatic cls_t classify(input logic [31:0] instr);
        int o;
        o = int'(instr[31:27]);
        if (o == 3 || o == 4) return C_MD;
        if (o <= 11)          return C_ALU;
        if (o == 26)          return C_NOP;
        if (o == 27)          return C_HALT;
        return C_ILL;
    endfunction

    function automatic int instrLen(input logic [31:0] instr);
        case (classify(instr))
            C_ALU:   return 6;
            C_MD:    return 7;
            default: return 4;
        endcase
    endfunction

    function automatic obs_t zeroObs();
        obs_t e;
        e = '0;
        return e;
    endfunction

    // Expected outputs during micro-step k (0 = T0) of an instruction.
    function automatic obs_t expStep(input logic [31:0] instr, input int k);
        obs_t e;
        cls_t c;
        int   a, b, cc;
        e  = '0;
        c  = classify(instr);
        a  = int'(instr[26:23]);
        b  = int'(instr[22:19]);
        cc = int'(instr[18:15]);
        if (k == 0) begin
            e.strobes[S_PCOUT] = 1; e.strobes[S_MARIN] = 1;
            e.strobes[S_INCPC] = 1; e.strobes[S_ZIN] = 1;
        end else if (k == 1) begin
            e.strobes[S_ZLO] = 1; e.strobes[S_PCIN] = 1;
            e.strobes[S_READ] = 1; e.strobes[S_MDRIN] = 1;
        end else if (k == 2) begin
            e.strobes[S_MDROUT] = 1; e.strobes[S_IRIN] = 1;
        end else if (k == 3) begin
            if (c == C_ALU || c == C_MD) begin
                e.reg_out[(c == C_ALU) ? b : a] = 1;
                e.strobes[S_YIN] = 1;
            end else if (c != C_HALT) begin
                e.done    = 1;
                e.illegal = (c == C_ILL);
            end
        end else if (k == 4) begin
            e.reg_out[(c == C_ALU) ? cc : b] = 1;
            e.opcode = instr[31:27];
            e.strobes[S_ZIN] = 1;
        end else if (k == 5) begin
            e.strobes[S_ZLO] = 1;
            if (c == C_ALU) begin
                e.reg_in[a] = 1;
                e.done      = 1;
            end else begin
                e.strobes[S_LOIN] = 1;
            end
        end else begin
            e.strobes[S_ZHI] = 1; e.strobes[S_HIIN] = 1; e.done = 1;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input obs_t expv);
        obs_t o;
        o.strobes = {PCout, incPC, MARin, Zin, PCin, Read, MDRin, MDRout, IRin,
                     Yin, ZLowOut, ZHighOut, HIin, LOin};
        o.reg_in  = reg_in;
        o.reg_out = reg_out;
        o.opcode  = opcode;
        o.done    = done;
        o.halted  = halted;
        o.illegal = illegal;
        checks++;
        assert (o === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, o, expv);
        end
    endtask

    // Called while in T0; walks every step of one instruction. run is driven
    // to mid_run on the inner steps and to last_run on the final step.
    task automatic applyStimulus(input logic [31:0] instr, input logic mid_run,
                                 input logic last_run, input string tag);
        int len;
        ir  = instr;
        len = instrLen(instr);
        for (int k = 0; k < len; k++) begin
            checkOutput($sformatf("%s k=%0d", tag, k), expStep(instr, k));
            run = (k == len - 1) ? last_run : mid_run;
            tick();
        end
    endtask

    // Called while in IDLE; stays idle n cycles, raising run on the last one.
    task automatic idleGap(input int n);
        for (int i = 0; i < n; i++) begin
            run = (i == n - 1);
            checkOutput($sformatf("idle %0d", i), zeroObs());
            tick();
        end
    endtask

    initial begin
        obs_t  hexp;
        logic [31:0] rnd, instr;
        logic [4:0]  op;
        int          sel, o;
        logic        lr;

        clr = 1'b1;
        run = 1'b1;
        ir  = 32'h0;
        tick();
        checkOutput("reset0", zeroObs());
        tick();
        checkOutput("reset1", zeroObs());
        clr = 1'b0;
        tick();

        applyStimulus(32'h00918000, 1'b1, 1'b1, "add_r1_r2_r3");
        applyStimulus({5'd1, 4'd4, 4'd5, 4'd6, 15'd0}, 1'b0, 1'b0, "sub_run_low");
        idleGap(2);
        applyStimulus(32'h1B380000, 1'b1, 1'b0, "mul_r6_r7");
        idleGap(1);
        applyStimulus(32'hF8000000, 1'b1, 1'b1, "illegal_1f");
        applyStimulus({5'd26, 27'h5A5A5A5}, 1'b0, 1'b1, "nop");
        applyStimulus({5'd4, 4'd0, 4'd15, 4'd9, 15'h7FFF}, 1'b0, 1'b1, "div_r0_r15");

        for (int n = 0; n < 40; n++) begin
            rnd = $urandom();
            sel = $urandom_range(0, 9);
            if (sel <= 4) begin
                o = $urandom_range(0, 9);
                if (o >= 3) o += 2;
            end else if (sel <= 7) begin
                o = $urandom_range(3, 4);
            end else if (sel == 8) begin
                o = 26;
            end else begin
                o = $urandom_range(12, 29);
                if (o >= 26) o += 2;
            end
            op    = 5'(o);
            instr = {op, rnd[26:0]};
            lr    = 1'($urandom_range(0, 1));
            applyStimulus(instr, 1'($urandom_range(0, 1)), lr, $sformatf("rand%0d", n));
            if (!lr) idleGap($urandom_range(1, 3));
        end

        ir = 32'h1B380000;
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("mul_clr k=%0d", k), expStep(32'h1B380000, k));
            run = 1'b1;
            if (k == 5) clr = 1'b1;
            tick();
        end
        checkOutput("clr_mid_idle", zeroObs());
        clr = 1'b0;
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("after_clr %0d", i), zeroObs());
        end
        idleGap(1);

        applyStimulus(32'hD8000000, 1'b1, 1'b1, "halt");
        hexp = zeroObs();
        hexp.halted = 1'b1;
        for (int i = 0; i < 20; i++) begin
            run = 1'b1;
            checkOutput($sformatf("halted %0d", i), hexp);
            tick();
        end
        clr = 1'b1;
        tick();
        checkOutput("halt_clr", zeroObs());
        clr = 1'b0;
        run = 1'b0;
        tick();
        checkOutput("halt_clr_idle", zeroObs());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
